fifo_write_ctrl: RTL and testbench
==================================

# fifo_write_ctrl

Parametrised write-side controller for the FIFO memory: the next generation of the basic write logic. It accepts write requests, registers the write data and address toward the memory array, and keeps its own occupancy count from the read side's pop strobe. It also generates full and programmable almost-full flags, supports any depth (not only powers of two), and optionally tracks overflow/underflow errors. It sits between the FIFO's producer interface and the memory array, beside the read logic.

## Interface
- MEM_SIZE, 4, number of memory entries; any value ≥ 2.
- WORD_SIZE, 6, data bits per entry.
- PTR_L, 3, pointer width; must satisfy 2^PTR_L ≥ MEM_SIZE.
- clk  in  1  single clock; all logic on posedge.
- reset  in  1  asynchronous, active-high reset.
- fifo_wr  in  1  producer write request.
- fifo_data_in  in  WORD_SIZE  producer write data.
- pop  in  1  one-cycle strobe from read logic: one entry consumed.
- af_thresh  in  PTR_L+1  almost-full threshold, quasi-static.
- err_clr  in  1  clears sticky error bits.
- push  out  1  memory write enable, one cycle per accepted write.
- wr_addr  out  PTR_L  memory address for the current push.
- data_out  out  WORD_SIZE  memory write data for the current push.
- wr_ptr  out  PTR_L  next free slot.
- count  out  PTR_L+1  current occupancy, 0..MEM_SIZE.
- fifo_full  out  1  count == MEM_SIZE.
- almost_full  out  1  count ≥ af_thresh.
- err  out  2  sticky flags: [0] overflow, [1] underflow.

## Operation
- Reset values: all outputs 0, including push, wr_addr, data_out, wr_ptr, count, fifo_full, almost_full and err.
- Acceptance rule: accept = fifo_wr && !fifo_full. It uses the registered fifo_full, so no combinational path exists from pop to acceptance.
- On accept:
  - push ← 1, wr_addr ← wr_ptr, data_out ← fifo_data_in.
  - wr_ptr ← (wr_ptr == MEM_SIZE-1) ? 0 : wr_ptr+1.
- No accept: push ← 0. wr_addr and data_out hold their values.
- Pop validity: pop_ok = pop && (count != 0).
- Count update: count ← count + accept − pop_ok, computed in PTR_L+1 bits; it never exceeds MEM_SIZE and never goes below 0.
- Flag update: fifo_full and almost_full are registered from the next count value, so they are coherent with count in the same cycle.
- Rejected write (fifo_wr while full): no push; wr_ptr and count are unaffected by the request.
- Ignored pop (pop when count==0): count is unchanged.
- Simultaneous accept and pop_ok: count is unchanged and push still asserts.
- Pop while full with fifo_wr high in the same cycle: the write is rejected (overflow). count drops to MEM_SIZE−1 and fifo_full clears next cycle.
- af_thresh = 0: almost_full is constantly 1. af_thresh > MEM_SIZE: almost_full is never asserted.
- Asserting reset mid-operation clears everything immediately. Any in-flight push drops asynchronously.

## Timing
- Latency: an accepted fifo_wr sampled at edge N gives push/wr_addr/data_out high and valid during cycle N→N+1. wr_ptr, count and the flags take their new values at edge N.
- Back-to-back writes sustain one push per cycle until full.
- The first accept is possible at the first edge after reset deasserts.
- err bits set at the edge of the offending event. err_clr takes priority over a same-cycle set.

## Configuration
- Macro: FIFO_WR_ERR_EN.
- Defined: the err register is implemented as described.
  - Overflow = fifo_wr && fifo_full.
  - Underflow = pop && count==0.
- Undefined: err is tied to 2'b00 and err_clr is ignored. Ports remain, and all other behaviour is identical.

## Structure
- Shared package fifo_pkg:
  - ERR_OVF=0 and ERR_UDF=1 bit indices.
  - ERR_W=2 constant.
- Sub-module ptr_wrap (parameters MOD, W): a wrapping pointer register with an increment enable. Used for wr_ptr; it will be reused by the read logic.

## Test plan
- Reset held then released with MEM_SIZE=4; 4 consecutive writes of 0x01..0x04:
  - wr_addr is 0,1,2,3 and push is high for 4 cycles.
  - wr_ptr wraps to 0, count=4, fifo_full=1.
- Full FIFO, fifo_wr high for 2 cycles:
  - no push; count stays 4.
  - err=2'b01 until an err_clr pulse, then 2'b00.
- count=2, fifo_wr and pop in the same cycle → push=1 and count stays 2.
- count=0, pop pulse → count stays 0 and err[1]=1. With FIFO_WR_ERR_EN undefined, err stays 0.
- MEM_SIZE=5, PTR_L=3, af_thresh=3; 6 writes:
  - wr_addr sequence 0..4, wr_ptr wraps 4→0.
  - almost_full rises when count reaches 3; 6th write rejected.
- Reset asserted mid-burst at count=3 → all outputs 0 asynchronously. The next write after release goes to wr_addr 0.

Source files
------------

// File: rtl/fifo_pkg.sv
// fifo_pkg: constants shared by the FIFO write and read controllers.
//   ERR_OVF / ERR_UDF : bit positions inside the sticky err vector.
//   ERR_W             : width of the err vector.
package fifo_pkg;

  localparam int ERR_OVF = 0;
  localparam int ERR_UDF = 1;
  localparam int ERR_W   = 2;

endpackage : fifo_pkg

// File: rtl/fifo_write_ctrl_ptr_wrap.sv
// ptr_wrap: pointer register that counts 0..MOD-1 and wraps back to 0.
// The modulus need not be a power of two. Shared by the write and read sides.
// Ports:
//   clk   : clock, posedge
//   reset : asynchronous active-high reset, clears ptr to 0
//   inc   : advance the pointer by one (with wrap) on this edge
//   ptr   : current pointer value
module ptr_wrap #(
  parameter int MOD = 4,
  parameter int W   = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] ptr
);

  // NOTE: state is updated with non-blocking assignments so every register
  // samples its inputs from before the edge, independent of block order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= (ptr == W'(MOD - 1)) ? '0 : ptr + 1'b1;
    end
  end

endmodule : ptr_wrap

// File: rtl/fifo_write_ctrl.sv
// fifo_write_ctrl: write-side controller of the FIFO.
// Accepts producer writes while not full, registers address/data toward the
// memory array, tracks occupancy from the read side's pop strobe and produces
// full / almost-full flags. Depth may be any value >= 2.
// Optional feature: define FIFO_WR_ERR_EN to implement the sticky
// overflow/underflow err register; otherwise err reads 2'b00.
// Ports:
//   clk, reset    : clock (posedge) and asynchronous active-high reset
//   fifo_wr       : producer write request
//   fifo_data_in  : producer write data
//   pop           : one entry consumed by the read logic (one-cycle strobe)
//   af_thresh     : almost-full threshold (quasi-static)
//   err_clr       : clears the sticky error bits
//   push          : memory write enable, one cycle per accepted write
//   wr_addr       : memory address for the current push
//   data_out      : memory write data for the current push
//   wr_ptr        : next free slot
//   count         : occupancy 0..MEM_SIZE
//   fifo_full     : count == MEM_SIZE
//   almost_full   : count >= af_thresh
//   err           : sticky flags, [ERR_OVF] overflow, [ERR_UDF] underflow
module fifo_write_ctrl
  import fifo_pkg::*;
#(
  parameter int MEM_SIZE  = 4,
  parameter int WORD_SIZE = 6,
  parameter int PTR_L     = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 fifo_wr,
  input  logic [WORD_SIZE-1:0] fifo_data_in,
  input  logic                 pop,
  input  logic [PTR_L:0]       af_thresh,
  input  logic                 err_clr,
  output logic                 push,
  output logic [PTR_L-1:0]     wr_addr,
  output logic [WORD_SIZE-1:0] data_out,
  output logic [PTR_L-1:0]     wr_ptr,
  output logic [PTR_L:0]       count,
  output logic                 fifo_full,
  output logic                 almost_full,
  output logic [ERR_W-1:0]     err
);

  localparam int CW = PTR_L + 1;

  logic          accept;
  logic          pop_ok;
  logic [CW-1:0] count_next;

  // Acceptance only looks at the registered full flag, so a same-cycle pop
  // cannot make room for a write: no combinational pop -> push path.
  assign accept     = fifo_wr && !fifo_full;
  assign pop_ok     = pop && (count != '0);
  assign count_next = count + CW'(accept) - CW'(pop_ok);

  ptr_wrap #(
    .MOD (MEM_SIZE),
    .W   (PTR_L)
  ) u_wr_ptr (
    .clk   (clk),
    .reset (reset),
    .inc   (accept),
    .ptr   (wr_ptr)
  );

  // Memory-side write port: address and data hold between pushes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      push     <= 1'b0;
      wr_addr  <= '0;
      data_out <= '0;
    end else begin
      push <= accept;
      if (accept) begin
        wr_addr  <= wr_ptr;
        data_out <= fifo_data_in;
      end
    end
  end

  // Flags are registered from count_next so they always agree with count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count       <= '0;
      fifo_full   <= 1'b0;
      almost_full <= 1'b0;
    end else begin
      count       <= count_next;
      fifo_full   <= (count_next == CW'(MEM_SIZE));
      almost_full <= (count_next >= af_thresh);
    end
  end

`ifdef FIFO_WR_ERR_EN
  // Clear wins over a set in the same cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err <= '0;
    end else if (err_clr) begin
      err <= '0;
    end else begin
      if (fifo_wr && fifo_full)      err[ERR_OVF] <= 1'b1;
      if (pop && (count == '0))      err[ERR_UDF] <= 1'b1;
    end
  end
`else
  logic unused_err_clr;
  assign unused_err_clr = err_clr;
  assign err            = '0;
`endif

endmodule : fifo_write_ctrl

// File: tb/tb_fifo_write_ctrl.sv
// Bench for fifo_write_ctrl: two instances (depth 4 and depth 5) driven by
// directed vectors. An occupancy/pointer model checks every output on every
// falling edge outside reset; literal checks pin the model at key points.
module tb_fifo_write_ctrl;

`ifdef FIFO_WR_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       wr[2];
  logic [5:0] din[2];
  logic       pop_i[2];
  logic [3:0] af[2];
  logic       clr[2];

  logic       push_o[2];
  logic [2:0] addr_o[2];
  logic [5:0] dout_o[2];
  logic [2:0] ptr_o[2];
  logic [3:0] cnt_o[2];
  logic       full_o[2];
  logic       af_o[2];
  logic [1:0] err_o[2];

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  fifo_write_ctrl #(.MEM_SIZE(4), .WORD_SIZE(6), .PTR_L(3)) dut4 (
    .clk(clk), .reset(reset), .fifo_wr(wr[0]), .fifo_data_in(din[0]),
    .pop(pop_i[0]), .af_thresh(af[0]), .err_clr(clr[0]),
    .push(push_o[0]), .wr_addr(addr_o[0]), .data_out(dout_o[0]),
    .wr_ptr(ptr_o[0]), .count(cnt_o[0]), .fifo_full(full_o[0]),
    .almost_full(af_o[0]), .err(err_o[0])
  );

  fifo_write_ctrl #(.MEM_SIZE(5), .WORD_SIZE(6), .PTR_L(3)) dut5 (
    .clk(clk), .reset(reset), .fifo_wr(wr[1]), .fifo_data_in(din[1]),
    .pop(pop_i[1]), .af_thresh(af[1]), .err_clr(clr[1]),
    .push(push_o[1]), .wr_addr(addr_o[1]), .data_out(dout_o[1]),
    .wr_ptr(ptr_o[1]), .count(cnt_o[1]), .fifo_full(full_o[1]),
    .almost_full(af_o[1]), .err(err_o[1])
  );

  function automatic int mem_of(input int i);
    return (i == 0) ? 4 : 5;
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int         m_cnt[2];
  int         m_ptr[2];
  int         m_addr[2];
  logic [5:0] m_data[2];
  bit         m_push[2];
  bit         m_af[2];
  logic [1:0] m_err[2];

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 2; i++) begin
        m_cnt[i] <= 0; m_ptr[i] <= 0; m_addr[i] <= 0; m_data[i] <= '0;
        m_push[i] <= 1'b0; m_af[i] <= 1'b0; m_err[i] <= 2'b00;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin : per_inst
        int   mem, nc;
        bit   full, acc, pok;
        logic [1:0] e;
        mem  = mem_of(i);
        full = (m_cnt[i] == mem);
        acc  = wr[i] && !full;
        pok  = pop_i[i] && (m_cnt[i] > 0);
        nc   = m_cnt[i] + (acc ? 1 : 0) - (pok ? 1 : 0);
        m_push[i] <= acc;
        if (acc) begin
          m_addr[i] <= m_ptr[i];
          m_data[i] <= din[i];
          m_ptr[i]  <= (m_ptr[i] + 1) % mem;
        end
        m_cnt[i] <= nc;
        m_af[i]  <= (nc >= int'(af[i]));
        e = m_err[i];
        if (ERR_EN) begin
          if (clr[i]) e = 2'b00;
          else begin
            if (wr[i] && full)            e[0] = 1'b1;
            if (pop_i[i] && m_cnt[i] == 0) e[1] = 1'b1;
          end
        end
        m_err[i] <= e;
      end
    end
  end

  // One compare process: every falling edge outside reset.
  always @(negedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 2; i++) begin
        check($sformatf("m%0d push", i),  32'(push_o[i]), 32'(m_push[i]));
        check($sformatf("m%0d count", i), 32'(cnt_o[i]),  32'(m_cnt[i]));
        check($sformatf("m%0d wr_ptr", i), 32'(ptr_o[i]), 32'(m_ptr[i]));
        check($sformatf("m%0d full", i),  32'(full_o[i]), 32'(m_cnt[i] == mem_of(i)));
        check($sformatf("m%0d af", i),    32'(af_o[i]),   32'(m_af[i]));
        check($sformatf("m%0d err", i),   32'(err_o[i]),  32'(m_err[i]));
        if (m_push[i]) begin
          check($sformatf("m%0d wr_addr", i),  32'(addr_o[i]), 32'(m_addr[i]));
          check($sformatf("m%0d data_out", i), 32'(dout_o[i]), 32'(m_data[i]));
        end
      end
    end
  end

  // Apply one cycle of inputs, return at the following falling edge.
  task automatic step(input logic w0, input logic [5:0] d0, input logic p0,
                      input logic w1, input logic [5:0] d1, input logic p1,
                      input logic c);
    wr[0] = w0; din[0] = d0; pop_i[0] = p0;
    wr[1] = w1; din[1] = d1; pop_i[1] = p1;
    clr[0] = c; clr[1] = c;
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      wr[i] = 1'b0; din[i] = '0; pop_i[i] = 1'b0; clr[i] = 1'b0; af[i] = 4'd3;
    end
    repeat (2) @(negedge clk);
    check("reset push",  32'(push_o[0]), 0);
    check("reset count", 32'(cnt_o[1]),  0);
    check("reset af",    32'(af_o[0]),   0);
    reset = 1'b0;

    // Burst of writes into both instances.
    step(1, 6'h01, 0, 1, 6'h11, 0, 0);
    check("w1 addr", 32'(addr_o[0]), 0);
    check("w1 data", 32'(dout_o[0]), 32'h01);
    step(1, 6'h02, 0, 1, 6'h12, 0, 0);
    check("w2 addr", 32'(addr_o[0]), 1);
    check("d5 af@2", 32'(af_o[1]), 0);
    step(1, 6'h03, 0, 1, 6'h13, 0, 0);
    check("w3 addr", 32'(addr_o[0]), 2);
    check("d5 af@3", 32'(af_o[1]), 1);
    step(1, 6'h04, 0, 1, 6'h14, 0, 0);
    check("w4 addr",  32'(addr_o[0]), 3);
    check("w4 push",  32'(push_o[0]), 1);
    check("w4 ptr",   32'(ptr_o[0]),  0);
    check("w4 count", 32'(cnt_o[0]),  4);
    check("w4 full",  32'(full_o[0]), 1);
    check("d5 ptr@4", 32'(ptr_o[1]),  4);
    step(1, 6'h05, 0, 1, 6'h15, 0, 0);
    check("ovf push",  32'(push_o[0]), 0);
    check("ovf count", 32'(cnt_o[0]),  4);
    check("ovf err",   32'(err_o[0]),  ERR_EN ? 1 : 0);
    check("d5 addr4",  32'(addr_o[1]), 4);
    check("d5 wrap",   32'(ptr_o[1]),  0);
    check("d5 full",   32'(full_o[1]), 1);
    step(1, 6'h06, 0, 1, 6'h16, 0, 0);
    check("d5 6th rej", 32'(push_o[1]), 0);
    check("d5 count5",  32'(cnt_o[1]),  5);
    step(0, 0, 0, 0, 0, 0, 0);
    check("err sticky", 32'(err_o[0]), ERR_EN ? 1 : 0);
    step(0, 0, 0, 0, 0, 0, 1);
    check("err clr", 32'(err_o[0]), 0);

    // Pop while full with a write in the same cycle: write is rejected.
    step(1, 6'h07, 1, 0, 0, 0, 0);
    check("popfull push",  32'(push_o[0]), 0);
    check("popfull count", 32'(cnt_o[0]),  3);
    check("popfull full",  32'(full_o[0]), 0);
    step(0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 1, 0, 0, 0, 0);
    check("pop count2", 32'(cnt_o[0]), 2);
    // Simultaneous accept and pop.
    step(1, 6'h2A, 1, 0, 0, 0, 0);
    check("wr+pop push",  32'(push_o[0]), 1);
    check("wr+pop count", 32'(cnt_o[0]),  2);
    check("wr+pop addr",  32'(addr_o[0]), 0);
    step(0, 0, 1, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0, 0);
    check("udf count", 32'(cnt_o[0]), 0);
    check("udf err",   32'(err_o[0]), ERR_EN ? 2 : 0);
    step(0, 0, 0, 0, 0, 0, 1);

    // Almost-full threshold extremes.
    af[0] = 4'd0;
    step(0, 0, 0, 0, 0, 0, 0);
    check("af thr0", 32'(af_o[0]), 1);
    af[0] = 4'd5;
    for (int k = 0; k < 4; k++) step(1, 6'(8'h30 + k), 0, 0, 0, 0, 0);
    check("af thr5 full", 32'(full_o[0]), 1);
    check("af thr5 af",   32'(af_o[0]),   0);
    for (int k = 0; k < 4; k++) step(0, 0, 1, 0, 0, 0, 0);

    // Reset in the middle of a burst.
    for (int k = 0; k < 3; k++) step(1, 6'(8'h20 + k), 0, 0, 0, 0, 0);
    check("burst count3", 32'(cnt_o[0]), 3);
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("async push",  32'(push_o[0]), 0);
    check("async count", 32'(cnt_o[0]),  0);
    check("async ptr",   32'(ptr_o[0]),  0);
    check("async data",  32'(dout_o[0]), 0);
    check("async full5", 32'(full_o[1]), 0);
    @(negedge clk);
    reset = 1'b0;
    step(1, 6'h3C, 0, 0, 0, 0, 0);
    check("post-rst addr",  32'(addr_o[0]), 0);
    check("post-rst push",  32'(push_o[0]), 1);
    check("post-rst count", 32'(cnt_o[0]),  1);
    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule : tb_fifo_write_ctrl
